alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one register-to-register ALU instruction over the
// shared bus through LDA, EXE and WB, driving ALU strobes and register-file
// enables. Inputs: clk, rst_n (sync, active-low), start, ir[15:0], data[W-1:0].
// Outputs (all registered): busy, done, err, reg_sel[3:0], reg_oe, reg_we,
// a_we, ialu, ealu, one-hot op lines _shl.._not, zflag.
module alu_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  ir,
    input  logic [W-1:0] data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [3:0]   reg_sel,
    output logic         reg_oe,
    output logic         reg_we,
    output logic         a_we,
    output logic         ialu,
    output logic         ealu,
    output logic         _shl,
    output logic         _add,
    output logic         _sub,
    output logic         _xor,
    output logic         _or,
    output logic         _and,
    output logic         _shr,
    output logic         _not,
    output logic         zflag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDA,
        S_EXE,
        S_WB,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] ir_q, ir_d;
    logic        zflag_q, zflag_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  sel_q, sel_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        awe_q, awe_d;
    logic        ialu_q, ialu_d;
    logic        ealu_q, ealu_d;
    logic [7:0]  op_q, op_d;

    // Low nibble of the instruction carries no meaning for this block.
    logic unused_ir;
    assign unused_ir = ^ir[3:0];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        zflag_d = zflag_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d    = ir[15:4];
                    state_d = ir[15] ? S_ERR : S_LDA;
                end
            end
            S_LDA:  state_d = S_EXE;
            S_EXE:  state_d = S_WB;
            S_WB: begin
                zflag_d = (data == '0);
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being
    // entered and the instruction that will be held during it.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = 1'b0;
        err_d  = 1'b0;
        sel_d  = 4'd0;
        oe_d   = 1'b0;
        we_d   = 1'b0;
        awe_d  = 1'b0;
        ialu_d = 1'b0;
        ealu_d = 1'b0;
        op_d   = 8'd0;
        unique case (state_d)
            S_LDA: begin
                sel_d = ir_d[7:4];
                oe_d  = 1'b1;
                awe_d = 1'b1;
            end
            S_EXE: begin
                sel_d  = ir_d[3:0];
                // not is unary; leave the bus floating
                oe_d   = (ir_d[10:8] != 3'd7);
                ialu_d = 1'b1;
                op_d   = 8'b0000_0001 << ir_d[10:8];
            end
            S_WB: begin
                sel_d  = ir_d[7:4];
                we_d   = 1'b1;
                ealu_d = 1'b1;
            end
            S_DONE: done_d = 1'b1;
            S_ERR: begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= 12'd0;
            zflag_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= 4'd0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            awe_q   <= 1'b0;
            ialu_q  <= 1'b0;
            ealu_q  <= 1'b0;
            op_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            awe_q   <= awe_d;
            ialu_q  <= ialu_d;
            ealu_q  <= ealu_d;
            op_q    <= op_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign reg_sel = sel_q;
    assign reg_oe  = oe_q;
    assign reg_we  = we_q;
    assign a_we    = awe_q;
    assign ialu    = ialu_q;
    assign ealu    = ealu_q;
    assign _shl    = op_q[0];
    assign _add    = op_q[1];
    assign _sub    = op_q[2];
    assign _xor    = op_q[3];
    assign _or     = op_q[4];
    assign _and    = op_q[5];
    assign _shr    = op_q[6];
    assign _not    = op_q[7];
    assign zflag   = zflag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with a register file and bus ALU
// environment; a scoreboard of per-cycle output vectors and write-back results.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ir_in;
    logic [15:0] data;
    logic        busy, done, err;
    logic [3:0]  reg_sel;
    logic        reg_oe, reg_we, a_we, ialu, ealu;
    logic        _shl, _add, _sub, _xor, _or, _and, _shr, _not;
    logic        zflag;

    int tests = 0;
    int fails = 0;

    logic [15:0] rf [16];
    logic [15:0] a_lat;
    logic [15:0] alu_out;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_idx;
    logic [15:0] ld_val;

    logic [20:0] vq [$];
    logic [19:0] rq [$];
    logic        exp_z;

    always #5 clk = ~clk;

    alu_sequencer #(.W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir_in), .data(data),
        .busy(busy), .done(done), .err(err), .reg_sel(reg_sel),
        .reg_oe(reg_oe), .reg_we(reg_we), .a_we(a_we),
        .ialu(ialu), .ealu(ealu),
        ._shl(_shl), ._add(_add), ._sub(_sub), ._xor(_xor),
        ._or(_or), ._and(_and), ._shr(_shr), ._not(_not),
        .zflag(zflag)
    );

    // Shared bus: register file or ALU result, 0 when floating.
    assign data = reg_oe ? rf[reg_sel] : (ealu ? alu_out : 16'h0000);

    always @(posedge clk) begin
        if (ld_en) rf[ld_idx] <= ld_val;
        else if (reg_we) rf[reg_sel] <= data;
        if (a_we) a_lat <= data;
        if (ialu) begin
            case (1'b1)
                _shl: alu_out <= a_lat << 1;
                _add: alu_out <= a_lat + data;
                _sub: alu_out <= a_lat - data;
                _xor: alu_out <= a_lat ^ data;
                _or:  alu_out <= a_lat | data;
                _and: alu_out <= a_lat & data;
                _shr: alu_out <= a_lat >> 1;
                _not: alu_out <= ~a_lat;
                default: alu_out <= 16'hDEAD;
            endcase
        end
    end

    function automatic logic [15:0] ref_alu(input logic [2:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            3'd0: return a << 1;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a ^ b;
            3'd4: return a | b;
            3'd5: return a & b;
            3'd6: return a >> 1;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [20:0] mk(
        input logic bz, input logic dn, input logic er,
        input logic [3:0] sel, input logic oe, input logic we,
        input logic aw, input logic ia, input logic ea,
        input logic [7:0] ops, input logic z);
        return {bz, dn, er, sel, oe, we, aw, ia, ea, ops, z};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++)
            vq.push_back(mk(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 8'd0, exp_z));
    endtask

    task automatic push_instr(input logic [15:0] ins);
        logic [3:0]  op, rd, rs;
        logic [15:0] res;
        logic        zn;
        op = ins[15:12];
        rd = ins[11:8];
        rs = ins[7:4];
        if (op > 4'd7) begin
            vq.push_back(mk(1, 1, 1, 4'd0, 0, 0, 0, 0, 0, 8'd0, exp_z));
        end else begin
            res = ref_alu(op[2:0], rf[rd], rf[rs]);
            zn  = (res == 16'h0000);
            vq.push_back(mk(1, 0, 0, rd, 1, 0, 1, 0, 0, 8'd0, exp_z));
            vq.push_back(mk(1, 0, 0, rs, op != 4'd7, 0, 0, 1, 0,
                            8'b0000_0001 << op[2:0], exp_z));
            vq.push_back(mk(1, 0, 0, rd, 0, 1, 0, 0, 1, 8'd0, exp_z));
            exp_z = zn;
            vq.push_back(mk(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 8'd0, exp_z));
            rq.push_back({rd, res});
        end
        push_idle(1);
    endtask

    task automatic step(input string tag);
        logic [20:0] o, e;
        @(negedge clk);
        o = {busy, done, err, reg_sel, reg_oe, reg_we, a_we, ialu, ealu,
             _not, _shr, _and, _or, _xor, _sub, _add, _shl, zflag};
        if (vq.size() == 0) begin
            chk({tag, "_underflow"}, 32'd1, 32'd0);
        end else begin
            e = vq.pop_front();
            chk(tag, {11'd0, o}, {11'd0, e});
        end
    endtask

    task automatic drain(input string tag);
        while (vq.size() != 0) step(tag);
    endtask

    task automatic check_res(input string tag);
        logic [19:0] r;
        while (rq.size() != 0) begin
            r = rq.pop_front();
            chk(tag, {16'd0, rf[r[19:16]]}, {16'd0, r[15:0]});
        end
    endtask

    // Called from a negedge; instruction sampled at the next rising edge.
    task automatic issue(input logic [15:0] ins);
        start = 1'b1;
        ir_in = ins;
        push_instr(ins);
        @(posedge clk);
        #1;
        start = 1'b0;
        ir_in = 16'hA5A5;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [15:0] val);
        ld_idx = idx;
        ld_val = val;
        ld_en  = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] saved;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        ir_in = 16'h1120;
        exp_z = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        a_lat   = 16'h0000;
        alu_out = 16'h0000;

        push_idle(2);
        step("reset_c0");
        step("reset_c1");
        rst_n = 1'b1;
        start = 1'b0;
        push_idle(1);
        step("post_reset");

        preload(4'd1, 16'h0005);
        preload(4'd2, 16'h0003);
        issue(16'h1120);
        drain("add");
        check_res("add_res");
        chk("add_r1", {16'd0, rf[1]}, 32'h0008);

        preload(4'd4, 16'h1234);
        preload(4'd5, 16'h1234);
        issue(16'h2450);
        drain("sub0");
        check_res("sub0_res");
        chk("sub0_r4", {16'd0, rf[4]}, 32'h0000);
        chk("sub0_z", {31'd0, zflag}, 32'd1);

        issue(16'h9120);
        drain("illegal");
        chk("illegal_z", {31'd0, zflag}, 32'd1);
        chk("illegal_r1", {16'd0, rf[1]}, 32'h0008);

        preload(4'd6, 16'h00F0);
        preload(4'd7, 16'h000F);
        issue(16'h4670);
        drain("or");
        check_res("or_res");
        chk("or_z", {31'd0, zflag}, 32'd0);

        preload(4'd3, 16'h00FF);
        issue(16'h7300);
        drain("not");
        check_res("not_res");
        chk("not_r3", {16'd0, rf[3]}, 32'hFF00);

        issue(16'h1330);
        drain("dbl");
        check_res("dbl_res");
        chk("dbl_r3", {16'd0, rf[3]}, 32'hFE00);

        // start pulsed during LDA/EXE/WB must be ignored, not queued
        preload(4'd8, 16'h0F0F);
        preload(4'd9, 16'h00FF);
        issue(16'h3890);
        step("poke_lda");
        start = 1'b1;
        ir_in = 16'h1120;
        step("poke_exe");
        step("poke_wb");
        start = 1'b0;
        drain("poke_tail");
        check_res("poke_res");
        chk("poke_r1", {16'd0, rf[1]}, 32'h0008);

        // reset sampled at the edge ending EXE aborts the instruction
        preload(4'd10, 16'h0001);
        saved = rf[10];
        issue(16'h1AA0);
        step("abort_lda");
        step("abort_exe");
        vq.delete();
        rq.delete();
        exp_z = 1'b0;
        rst_n = 1'b0;
        push_idle(3);
        step("abort_rst");
        rst_n = 1'b1;
        step("abort_after0");
        step("abort_after1");
        chk("abort_r10", {16'd0, rf[10]}, {16'd0, saved});

        // sequencer still usable after abort
        issue(16'h5AA0);
        drain("and_after");
        check_res("and_res");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
